// File: rtl/rom_loader_dma.sv
// Command-driven flash-to-SDRAM copier: toggle req/ack flash reads, single-cycle
// SDRAM write strobes, optional byte swap, running checksum and per-wait timeout.
module rom_loader_dma #(
  parameter int DATA_W   = 16,
  parameter int SRC_AW   = 23,
  parameter int DST_AW   = 25,
  parameter int LEN_W    = 24,
  parameter int TIMEOUT  = 4095,
  parameter int WR_GUARD = 3
) (
  input  logic              iclk,
  input  logic              ireset_n,
  input  logic              istart,
  input  logic [SRC_AW-1:0] isrc_base,
  input  logic [DST_AW-1:0] idst_base,
  input  logic [LEN_W-1:0]  ilen,
  input  logic              iswap,
  output logic              oloading,
  output logic              odone,
  output logic              oerror,
  output logic [15:0]       ochecksum,
  output logic [SRC_AW-1:0] ofl_addr,
  input  logic [DATA_W-1:0] ifl_data,
  output logic              ofl_req,
  input  logic              ifl_ack,
  output logic              orom_load_wr,
  output logic [DST_AW-1:0] oram_addr,
  output logic [DATA_W-1:0] oram_wrdata,
  input  logic              irom_load_wait
);

  localparam int TMR_MAX = (TIMEOUT > WR_GUARD) ? TIMEOUT : WR_GUARD;
  localparam int TMR_W   = $clog2(TMR_MAX + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_FL_REQ, S_FL_WAIT, S_WR_PULSE, S_WR_WAIT, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t             r_state, w_next;
  logic [SRC_AW-1:0]  r_src_base;
  logic [DST_AW-1:0]  r_dst_base;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_offset;
  logic               r_swap;
  logic [TMR_W-1:0]   r_timer;
  logic               r_loading, r_done, r_error;
  logic               r_fl_req, r_wr;
  logic [DATA_W-1:0]  r_wrdata;
  logic [15:0]        r_checksum;
  logic               r_ack_meta, r_ack_s, r_wait_meta, r_wait_s;

  logic [DATA_W-1:0]  w_word;
  logic [15:0]        w_sum_word;
  logic               w_last, w_timeout, w_guard_ok, w_start_zero;

  generate
    if (DATA_W == 16) begin : g_swap
      assign w_word = r_swap ? {ifl_data[7:0], ifl_data[15:8]} : ifl_data;
    end else begin : g_noswap
      assign w_word = ifl_data;
    end
  endgenerate

  assign w_sum_word   = 16'(w_word);
  assign w_start_zero = (ilen[LEN_W-1:1] == '0);
  assign w_last       = ({1'b0, r_offset} + (LEN_W+1)'(2)) >= {1'b0, r_len};
  // The timer counts from 0 on entry, so TIMEOUT-1 is the last cycle spent waiting.
  assign w_timeout    = (TIMEOUT != 0) && (r_timer >= TMR_W'(TIMEOUT - 1));
  assign w_guard_ok   = r_timer >= TMR_W'(WR_GUARD);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      r_ack_meta  <= 1'b0;
      r_ack_s     <= 1'b0;
      r_wait_meta <= 1'b0;
      r_wait_s    <= 1'b0;
    end else begin
      r_ack_meta  <= ifl_ack;
      r_ack_s     <= r_ack_meta;
      r_wait_meta <= irom_load_wait;
      r_wait_s    <= r_wait_meta;
    end
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  // NOTE: w_next is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR:
        if (istart) w_next = w_start_zero ? S_DONE : S_FL_REQ;
      S_FL_REQ:   w_next = S_FL_WAIT;
      S_FL_WAIT:
        if (r_ack_s == r_fl_req) w_next = S_WR_PULSE;
        else if (w_timeout)      w_next = S_ERROR;
      S_WR_PULSE: w_next = S_WR_WAIT;
      S_WR_WAIT:
        if (w_guard_ok && !r_wait_s) w_next = S_NEXT;
        else if (w_timeout)          w_next = S_ERROR;
      S_NEXT:     w_next = w_last ? S_DONE : S_FL_REQ;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      r_src_base <= '0;
      r_dst_base <= '0;
      r_len      <= '0;
      r_offset   <= '0;
      r_swap     <= 1'b0;
      r_timer    <= '0;
      r_loading  <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_fl_req   <= 1'b0;
      r_wr       <= 1'b0;
      r_wrdata   <= '0;
      r_checksum <= '0;
    end else begin
      if (w_next != r_state)
        r_timer <= '0;
      else if ((r_state == S_FL_WAIT || r_state == S_WR_WAIT) && r_timer != '1)
        r_timer <= r_timer + 1'b1;

      r_wr      <= (r_state == S_WR_PULSE);
      r_loading <= w_next inside {S_FL_REQ, S_FL_WAIT, S_WR_PULSE, S_WR_WAIT, S_NEXT};
      r_done    <= (w_next == S_DONE);
      r_error   <= (w_next == S_ERROR);

      case (r_state)
        S_IDLE, S_DONE, S_ERROR:
          if (istart) begin
            r_src_base <= {isrc_base[SRC_AW-1:1], 1'b0};
            r_dst_base <= {idst_base[DST_AW-1:1], 1'b0};
            r_len      <= {ilen[LEN_W-1:1], 1'b0};
            r_swap     <= iswap;
            r_offset   <= '0;
            r_checksum <= '0;
          end
        S_FL_REQ:   r_fl_req <= ~r_ack_s;
        S_WR_PULSE: begin
          r_wrdata   <= w_word;
          r_checksum <= r_checksum + w_sum_word;
        end
        S_NEXT:
          if (!w_last) r_offset <= r_offset + LEN_W'(2);
        default: ;
      endcase
    end
  end

  assign oloading     = r_loading;
  assign odone        = r_done;
  assign oerror       = r_error;
  assign ochecksum    = r_checksum;
  assign ofl_req      = r_fl_req;
  assign orom_load_wr = r_wr;
  assign oram_wrdata  = r_wrdata;
  assign ofl_addr     = r_src_base + SRC_AW'(r_offset);
  assign oram_addr    = r_dst_base + DST_AW'(r_offset);

endmodule
